// File: rtl/wb_ram8k_ctrl_if.sv
// Wishbone classic slave port bundle for the 8K x 32 RAM controller.
interface wb_ram8k_ctrl_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_ram8k_ctrl.sv
// Wishbone classic slave in front of one RAM_8Kx32 macro: decodes a 32 KB window,
// issues single-cycle RAM enables, waits out the read latency and returns ACK/ERR.
module wb_ram8k_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic          CLK,
  input  logic          RST,
  wb_ram8k_ctrl_if.slave wb,
  output logic          ram_EN,
  output logic [3:0]    ram_WE,
  output logic [12:0]   ram_A,
  output logic [31:0]   ram_Di,
  input  logic [31:0]   ram_Do
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_ACK     = 2'd2,
    S_ERR     = 2'd3
  } state_e;

  localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] dat_q, dat_d;
  logic        req_s;
  logic        hit_s;
  logic        adr_lo_unused;

  assign req_s = wb.wb_cyc_i & wb.wb_stb_i;
  assign hit_s = (wb.wb_adr_i[31:15] == BASE_ADDR[31:15]);
  assign adr_lo_unused = ^wb.wb_adr_i[1:0];

  assign ram_A  = wb.wb_adr_i[14:2];
  assign ram_Di = wb.wb_dat_i;
  // The macro is only touched in IDLE, so a request held through ACK is never re-issued.
  assign ram_EN = ~RST & (state_q == S_IDLE) & req_s & hit_s;
  assign ram_WE = (ram_EN & wb.wb_we_i) ? wb.wb_sel_i : 4'b0000;

  assign wb.wb_ack_o = (state_q == S_ACK);
  assign wb.wb_err_o = (state_q == S_ERR);
  assign wb.wb_dat_o = dat_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          if (!hit_s) begin
            state_d = S_ERR;
          end else if (wb.wb_we_i) begin
            state_d = S_ACK;
          end else begin
            state_d = S_RD_WAIT;
            cnt_d   = LAT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (!wb.wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 2'd0) begin
          dat_d   = ram_Do;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      dat_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
    end
  end

endmodule
